// File: rtl/seq_pc_ctrl.sv
// Fetch/run controller: program counter, writable jump table, req/done run handshake.
// Optional macro JUMP_CNT_EN adds a saturating jump_cnt output.
module seq_pc_ctrl #(
   parameter int D          = 12,
   parameter int LW         = 5,
   parameter int START_ADDR = 0,
   parameter int HALT_ADDR  = 128,
   parameter int CW         = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic          stall,
   input  logic          halt,
   input  logic          reljump_en,
   input  logic          absjump_en,
   input  logic [LW-1:0] lut_addr,
   input  logic          lut_wr_en,
   input  logic [LW-1:0] lut_wr_addr,
   input  logic [D-1:0]  lut_wr_data,
   output logic [D-1:0]  prog_ctr,
   output logic          running,
   output logic          done,
   output logic [CW-1:0] cycle_cnt
`ifdef JUMP_CNT_EN
   ,
   output logic [CW-1:0] jump_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   localparam logic [D-1:0]  START_PC = START_ADDR[D-1:0];
   localparam logic [D-1:0]  HALT_PC  = HALT_ADDR[D-1:0];
   // An out-of-range halt address can never be reached by a D-bit PC.
   localparam logic          HALT_OK  = (HALT_ADDR < (1 << D));
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [D-1:0]  PC_ONE   = {{(D-1){1'b0}}, 1'b1};

   state_t          r_state, w_state_nxt;
   logic [D-1:0]    r_pc, w_pc_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic            r_running, r_done;
   logic [D-1:0]    r_table [2**LW];
   logic [D-1:0]    w_target;
   logic [D-1:0]    w_next_pc;

   assign w_target = r_table[lut_addr];

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_cnt_nxt   = r_cnt;
      if (stall)           w_next_pc = r_pc;
      else if (absjump_en) w_next_pc = w_target;
      else if (reljump_en) w_next_pc = r_pc + w_target;
      else                 w_next_pc = r_pc + PC_ONE;
      case (r_state)
         S_IDLE: begin
            w_pc_nxt = START_PC;
            if (req) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = {CW{1'b0}};
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + CNT_ONE;
            else                  w_cnt_nxt = r_cnt;
            if (halt) begin
               w_state_nxt = S_DONE;
            end else if (HALT_OK && (w_next_pc == HALT_PC)) begin
               w_state_nxt = S_DONE;
               w_pc_nxt    = HALT_PC;
            end else begin
               w_pc_nxt    = w_next_pc;
            end
         end
         S_DONE: begin
            if (!req) begin
               w_state_nxt = S_IDLE;
               w_pc_nxt    = START_PC;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_pc_nxt    = START_PC;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_pc      <= START_PC;
         r_cnt     <= {CW{1'b0}};
         r_running <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_cnt     <= w_cnt_nxt;
         r_running <= (w_state_nxt == S_RUN);
         r_done    <= (w_state_nxt == S_DONE);
      end
   end

   // Registered table write: a same-cycle read still sees the old entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2**LW; i++) r_table[i] <= {D{1'b0}};
      end else if (lut_wr_en) begin
         r_table[lut_wr_addr] <= lut_wr_data;
      end
   end

`ifdef JUMP_CNT_EN
   logic [CW-1:0] r_jcnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_jcnt <= {CW{1'b0}};
      end else if (r_state == S_IDLE && req) begin
         r_jcnt <= {CW{1'b0}};
      end else if (r_state == S_RUN && !stall && !halt && (absjump_en || reljump_en)
                   && r_jcnt != CNT_MAX) begin
         r_jcnt <= r_jcnt + CNT_ONE;
      end
   end

   assign jump_cnt = r_jcnt;
`endif

   assign prog_ctr  = r_pc;
   assign running   = r_running;
   assign done      = r_done;
   assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_seq_pc_ctrl.sv
// Directed self-checking bench for seq_pc_ctrl (default parameters).
module tb_seq_pc_ctrl;

   logic        clk = 1'b0;
   logic        reset, req, stall, halt, reljump_en, absjump_en;
   logic [4:0]  lut_addr, lut_wr_addr;
   logic        lut_wr_en;
   logic [11:0] lut_wr_data;
   logic [11:0] prog_ctr;
   logic        running, done;
   logic [15:0] cycle_cnt;
`ifdef JUMP_CNT_EN
   logic [15:0] jump_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   seq_pc_ctrl dut (
      .clk(clk), .reset(reset), .req(req), .stall(stall), .halt(halt),
      .reljump_en(reljump_en), .absjump_en(absjump_en), .lut_addr(lut_addr),
      .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
      .prog_ctr(prog_ctr), .running(running), .done(done), .cycle_cnt(cycle_cnt)
`ifdef JUMP_CNT_EN
      , .jump_cnt(jump_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [11:0] pc, input logic run,
                            input logic dn, input logic [15:0] cnt);
      chk({tag, ".pc"}, {20'd0, prog_ctr}, {20'd0, pc});
      chk({tag, ".running"}, {31'd0, running}, {31'd0, run});
      chk({tag, ".done"}, {31'd0, done}, {31'd0, dn});
      chk({tag, ".cycle_cnt"}, {16'd0, cycle_cnt}, {16'd0, cnt});
   endtask

   task automatic wr(input logic [4:0] a, input logic [11:0] d);
      lut_wr_en = 1'b1; lut_wr_addr = a; lut_wr_data = d;
      step(1);
      lut_wr_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; stall = 1'b0; halt = 1'b0;
      reljump_en = 1'b0; absjump_en = 1'b0; lut_addr = 5'd0;
      lut_wr_en = 1'b0; lut_wr_addr = 5'd0; lut_wr_data = 12'd0;
      step(2);
      chk_state("reset", 12'd0, 1'b0, 1'b0, 16'd0);
      reset = 1'b0;

      // Plain count from 0 to the halt address.
      req = 1'b1;
      step(1);
      chk_state("run_start", 12'd0, 1'b1, 1'b0, 16'd0);
      step(127);
      chk_state("pc127", 12'd127, 1'b1, 1'b0, 16'd127);
      step(1);
      chk_state("halt128", 12'd128, 1'b0, 1'b1, 16'd128);
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk_state("done_hold", 12'd128, 1'b0, 1'b1, 16'd128);
      end
      req = 1'b0;
      step(1);
      chk_state("to_idle", 12'd0, 1'b0, 1'b0, 16'd128);

      wr(5'd3, 12'd40);
      wr(5'd4, 12'hFFE);
      wr(5'd5, 12'd20);

      req = 1'b1;
      step(1);
      chk_state("run2_start", 12'd0, 1'b1, 1'b0, 16'd0);
      step(5);
      chk_state("pc5", 12'd5, 1'b1, 1'b0, 16'd5);
      stall = 1'b1;
      step(3);
      chk_state("stall3", 12'd5, 1'b1, 1'b0, 16'd8);
      stall = 1'b0;
      step(5);
      chk_state("pc10", 12'd10, 1'b1, 1'b0, 16'd13);

      absjump_en = 1'b1; lut_addr = 5'd3;
      step(1);
      chk_state("abs40", 12'd40, 1'b1, 1'b0, 16'd14);
      lut_addr = 5'd5;
      step(1);
      chk_state("abs20", 12'd20, 1'b1, 1'b0, 16'd15);
      reljump_en = 1'b1; lut_addr = 5'd4;
      step(1);
      chk_state("abs_wins", 12'hFFE, 1'b1, 1'b0, 16'd16);
      absjump_en = 1'b0; reljump_en = 1'b0;
      step(1);
      chk_state("pcFFF", 12'hFFF, 1'b1, 1'b0, 16'd17);
      step(1);
      chk_state("wrap0", 12'd0, 1'b1, 1'b0, 16'd18);
      absjump_en = 1'b1; lut_addr = 5'd5;
      step(1);
      chk("back20", {20'd0, prog_ctr}, 32'd20);
      absjump_en = 1'b0; reljump_en = 1'b1; lut_addr = 5'd4;
      step(1);
      chk_state("rel18", 12'd18, 1'b1, 1'b0, 16'd20);
      reljump_en = 1'b0; stall = 1'b1; absjump_en = 1'b1; lut_addr = 5'd5;
      step(1);
      chk_state("stall_over_abs", 12'd18, 1'b1, 1'b0, 16'd21);
      stall = 1'b0; lut_addr = 5'd3;
      lut_wr_en = 1'b1; lut_wr_addr = 5'd3; lut_wr_data = 12'd100;
      step(1);
      lut_wr_en = 1'b0;
      chk("rw_old_value", {20'd0, prog_ctr}, 32'd40);
      step(1);
      chk_state("rw_new_value", 12'd100, 1'b1, 1'b0, 16'd23);
`ifdef JUMP_CNT_EN
      chk("jump_cnt7", {16'd0, jump_cnt}, 32'd7);
`endif

      absjump_en = 1'b0; stall = 1'b1; halt = 1'b1;
      step(1);
      chk_state("halt_stall", 12'd100, 1'b0, 1'b1, 16'd24);
      stall = 1'b0; halt = 1'b0; absjump_en = 1'b1; lut_addr = 5'd5;
      wr(5'd6, 12'd50);
      chk_state("done_frozen", 12'd100, 1'b0, 1'b1, 16'd24);
`ifdef JUMP_CNT_EN
      chk("jump_cnt_frozen", {16'd0, jump_cnt}, 32'd7);
`endif
      absjump_en = 1'b0; req = 1'b0;
      step(1);
      chk_state("idle2", 12'd0, 1'b0, 1'b0, 16'd24);

      req = 1'b1;
      step(1);
      chk_state("run3_start", 12'd0, 1'b1, 1'b0, 16'd0);
`ifdef JUMP_CNT_EN
      chk("jump_cnt_clr", {16'd0, jump_cnt}, 32'd0);
`endif
      absjump_en = 1'b1; lut_addr = 5'd6;
      step(1);
      chk("done_write", {20'd0, prog_ctr}, 32'd50);
      absjump_en = 1'b0; reset = 1'b1; req = 1'b0;
      step(1);
      chk_state("reset_midrun", 12'd0, 1'b0, 1'b0, 16'd0);
      reset = 1'b0;
      step(1);
      chk_state("idle_after_reset", 12'd0, 1'b0, 1'b0, 16'd0);

      // Table must be cleared: jumping to entry 3 lands on 0, not 100.
      req = 1'b1;
      step(1);
      absjump_en = 1'b1; lut_addr = 5'd3;
      step(1);
      chk_state("table_cleared", 12'd0, 1'b1, 1'b0, 16'd1);
      absjump_en = 1'b0; req = 1'b0;
      step(1);
      chk_state("req_drop_ignored", 12'd1, 1'b1, 1'b0, 16'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
